// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - triggered single-frame ADC capture into a sample RAM
module wave_capture #(
    parameter int DEPTH   = 1080,
    parameter int HOLDOFF = 4_999_500
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        oscen,
    input  logic        sample_en,
    input  logic [7:0]  ad_data_in,
    input  logic [7:0]  trig_level,
    input  logic [1:0]  trig_mode,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_done
);
    localparam int          HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [10:0] LAST_ADDR = 11'(DEPTH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {IDLE, ARM, FILL, HOLD} state_t;

    state_t        state, state_nxt;
    logic [10:0]   count, count_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [7:0]    prev, prev_nxt;
    logic          prev_valid, prev_valid_nxt;
    logic          wr_en_nxt, frame_done_nxt;
    logic [10:0]   wr_addr_nxt;
    logic [7:0]    wr_data_nxt;
    logic          trig_hit;

    // Edge modes need a previous sample from this arming; modes 00/11 fire on any sample.
    always_comb begin
        case (trig_mode)
            2'b01:   trig_hit = prev_valid && (prev < trig_level) && (ad_data_in >= trig_level);
            2'b10:   trig_hit = prev_valid && (prev > trig_level) && (ad_data_in <= trig_level);
            default: trig_hit = 1'b1;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            hold_cnt   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            hold_cnt   <= hold_nxt;
            prev       <= prev_nxt;
            prev_valid <= prev_valid_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        hold_nxt       = hold_cnt;
        prev_nxt       = prev;
        prev_valid_nxt = prev_valid;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        frame_done_nxt = 1'b0;
        if (!oscen) begin
            state_nxt      = IDLE;
            count_nxt      = '0;
            hold_nxt       = '0;
            prev_valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt      = ARM;
                    prev_valid_nxt = 1'b0;
                end
                ARM: if (sample_en) begin
                    prev_nxt       = ad_data_in;
                    prev_valid_nxt = 1'b1;
                    if (trig_hit) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = '0;
                        wr_data_nxt = ad_data_in;
                        count_nxt   = 11'd1;
                        state_nxt   = FILL;
                    end
                end
                FILL: if (sample_en) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = count;
                    wr_data_nxt = ad_data_in;
                    if (count == LAST_ADDR) begin
                        frame_done_nxt = 1'b1;
                        count_nxt      = '0;
                        hold_nxt       = '0;
                        state_nxt      = HOLD;
                    end else begin
                        count_nxt = count + 11'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt       = '0;
                        prev_valid_nxt = 1'b0;
                        state_nxt      = ARM;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - self-checking bench for wave_capture
module tb_wave_capture;
    localparam int DEPTH   = 1080;
    localparam int HOLDOFF = 40;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        oscen = 1'b0;
    logic        sample_en = 1'b0;
    logic [7:0]  ad_data_in = '0;
    logic [7:0]  trig_level = '0;
    logic [1:0]  trig_mode = '0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        frame_done;

    wave_capture #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .oscen(oscen), .sample_en(sample_en),
        .ad_data_in(ad_data_in), .trig_level(trig_level), .trig_mode(trig_mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk_50M = ~clk_50M;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: phase of the capture, frame position and a holdoff countdown.
    localparam int P_IDLE = 0, P_ARM = 1, P_FILL = 2, P_HOLD = 3;
    int ph = P_IDLE, pos = 0, rest = 0, last = 0;
    bit have_last = 0, fire = 0;
    bit e_we = 0, e_fd = 0;
    int e_addr = 0, e_data = 0;

    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            ph = P_IDLE; pos = 0; rest = 0; last = 0; have_last = 0;
            e_we = 0; e_fd = 0; e_addr = 0; e_data = 0;
        end else begin
            e_we = 0;
            e_fd = 0;
            if (!oscen) begin
                ph = P_IDLE;
            end else if (ph == P_IDLE) begin
                ph = P_ARM;
                have_last = 0;
            end else if (ph == P_ARM) begin
                if (sample_en) begin
                    if (trig_mode == 2'b01)
                        fire = have_last && last < int'(trig_level) && int'(ad_data_in) >= int'(trig_level);
                    else if (trig_mode == 2'b10)
                        fire = have_last && last > int'(trig_level) && int'(ad_data_in) <= int'(trig_level);
                    else
                        fire = 1;
                    last = ad_data_in;
                    have_last = 1;
                    if (fire) begin
                        e_we = 1; e_addr = 0; e_data = ad_data_in;
                        pos = 1; ph = P_FILL;
                    end
                end
            end else if (ph == P_FILL) begin
                if (sample_en) begin
                    e_we = 1; e_addr = pos; e_data = ad_data_in;
                    if (pos == DEPTH - 1) begin
                        e_fd = 1; ph = P_HOLD; rest = HOLDOFF;
                    end else begin
                        pos++;
                    end
                end
            end else begin
                rest--;
                if (rest == 0) begin
                    ph = P_ARM;
                    have_last = 0;
                end
            end
        end
    end

    int cycn = 0, n_wr = 0, n_fd = 0, max_addr = -1, first_addr = -1, first_data = -1;
    int fd_cyc = -1, wr_at_fd = 0, post_fd_cyc = -1, post_fd_addr = -1, ramp_bad = 0;
    bit ramp_on = 0;

    always @(negedge clk_50M) begin
        cycn++;
        chk("wr_en", wr_en, e_we);
        chk("frame_done", frame_done, e_fd);
        chk("busy", busy, ph != P_IDLE);
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
        if (wr_en) begin
            n_wr++;
            if (first_addr < 0) begin
                first_addr = wr_addr;
                first_data = wr_data;
            end
            if (int'(wr_addr) > max_addr) max_addr = wr_addr;
            if (ramp_on && wr_data != wr_addr[7:0]) ramp_bad++;
            if (fd_cyc >= 0 && post_fd_cyc < 0 && cycn > fd_cyc) begin
                post_fd_cyc = cycn;
                post_fd_addr = wr_addr;
            end
        end
        if (frame_done) begin
            n_fd++;
            fd_cyc = cycn;
            wr_at_fd = n_wr;
        end
    end

    task automatic clr();
        n_wr = 0; n_fd = 0; max_addr = -1; first_addr = -1; first_data = -1;
        fd_cyc = -1; wr_at_fd = 0; post_fd_cyc = -1; post_fd_addr = -1;
    endtask

    task automatic cyc(input bit se, input int d);
        sample_en = se;
        ad_data_in = 8'(d);
        @(posedge clk_50M);
        #1;
    endtask

    task automatic stop_osc();
        oscen = 1'b0;
        cyc(0, 0);
        cyc(0, 0);
        clr();
    endtask

    initial begin
        repeat (3) cyc(0, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        chk("idle_after_rst", busy, 0);

        // Free-run, one sample every 4th cycle, data tracks address
        clr();
        ramp_on = 1;
        trig_mode = 2'b00;
        oscen = 1'b1;
        for (int k = 0; k < 4 * DEPTH + 40 && n_fd == 0; k++) cyc(k % 4 == 0, n_wr);
        ramp_on = 0;
        chk("A_frames", n_fd, 1);
        chk("A_writes", wr_at_fd, DEPTH);
        chk("A_max_addr", max_addr, DEPTH - 1);
        chk("A_ramp_bad", ramp_bad, 0);
        for (int k = 0; k < HOLDOFF + 12; k++) cyc(k % 4 == 0, k);
        chk("A_hold_quiet", (post_fd_cyc - fd_cyc) > HOLDOFF, 1);
        chk("A_rearm_addr", post_fd_addr, 0);

        // Back-to-back samples across the last address
        stop_osc();
        oscen = 1'b1;
        for (int k = 0; k < DEPTH + HOLDOFF + 20 && post_fd_cyc < 0; k++) cyc(1, $urandom_range(0, 255));
        chk("B_writes", wr_at_fd, DEPTH);
        chk("B_max_addr", max_addr, DEPTH - 1);
        chk("B_gap", post_fd_cyc - fd_cyc, HOLDOFF + 1);
        chk("B_rearm_addr", post_fd_addr, 0);

        // Rising edge at 128; the first sample after arming never triggers
        stop_osc();
        trig_mode = 2'b01;
        trig_level = 8'd128;
        oscen = 1'b1;
        cyc(0, 0);
        cyc(1, 130); cyc(1, 140); cyc(1, 120); cyc(1, 125); cyc(1, 130);
        cyc(0, 0); cyc(0, 0);
        chk("C_writes", n_wr, 1);
        chk("C_addr", first_addr, 0);
        chk("C_data", first_data, 130);

        // Falling edge at 100, then a live trigger change mid-frame
        stop_osc();
        trig_mode = 2'b10;
        trig_level = 8'd100;
        oscen = 1'b1;
        cyc(0, 0);
        cyc(1, 50); cyc(1, 110); cyc(1, 90);
        cyc(0, 0); cyc(0, 0);
        chk("D_writes", n_wr, 1);
        chk("D_addr", first_addr, 0);
        chk("D_data", first_data, 90);
        trig_mode = 2'b01;
        trig_level = 8'hff;
        cyc(1, 7); cyc(1, 9); cyc(0, 0);
        chk("D_fill_continues", n_wr, 3);
        chk("D_max_addr", max_addr, 2);

        // Abort at address 500
        stop_osc();
        trig_mode = 2'b00;
        oscen = 1'b1;
        for (int k = 0; k < DEPTH && !(wr_en && wr_addr == 11'd500); k++) cyc(1, k);
        chk("E_reached_500", wr_addr, 500);
        oscen = 1'b0;
        cyc(1, 1);
        chk("E_wr_en_low", wr_en, 0);
        chk("E_busy_low", busy, 0);
        cyc(1, 2); cyc(1, 3);
        chk("E_no_frame_done", n_fd, 0);
        chk("E_max_addr", max_addr, 500);
        oscen = 1'b1;
        clr();
        for (int k = 0; k < 10 && n_wr == 0; k++) cyc(1, k + 20);
        chk("E_restart_addr", first_addr, 0);

        // Asynchronous reset mid-FILL
        for (int k = 0; k < 300; k++) cyc(1, k);
        rst_n = 1'b0;
        #1;
        chk("F_fill_wr_en", wr_en, 0);
        chk("F_fill_wr_addr", wr_addr, 0);
        chk("F_fill_wr_data", wr_data, 0);
        chk("F_fill_busy", busy, 0);
        cyc(0, 0); cyc(0, 0);
        rst_n = 1'b1;
        clr();
        for (int k = 0; k < 10 && n_wr == 0; k++) cyc(1, k + 77);
        chk("F_fill_resume_addr", first_addr, 0);

        // Asynchronous reset mid-HOLD
        for (int k = 0; k < DEPTH + 5 && n_fd == 0; k++) cyc(1, k);
        repeat (10) cyc(0, 0);
        chk("F_hold_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("F_hold_busy_rst", busy, 0);
        chk("F_hold_wr_addr", wr_addr, 0);
        chk("F_hold_wr_data", wr_data, 0);
        cyc(0, 0);
        rst_n = 1'b1;
        clr();
        for (int k = 0; k < 10 && n_wr == 0; k++) cyc(1, k + 5);
        chk("F_hold_resume_addr", first_addr, 0);
        chk("F_hold_resume_data", first_data, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
